// File: rtl/imem_load_ctrl_pkg.sv
// Shared definitions for the instruction-memory load controller: state encoding,
// memory geometry constants and the word-count clamp.
package imem_load_ctrl_pkg;

  localparam int          IMEM_DEPTH     = 128;
  localparam int          IMEM_AW        = 7;
  localparam logic [31:0] IMEM_MAX_BADDR = 32'h1FC;
  localparam logic [31:0] INSTR_NOP      = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RUN   = 2'd3
  } ctrl_state_e;

  // Requests larger than the memory are trimmed so the word pointer can never wrap.
  function automatic logic [7:0] clamp_words(input logic [7:0] req, input int depth);
    if (int'(req) > depth) return 8'(depth);
    return req;
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k];
// word_ready stays high from the fourth byte until the next clear.
module imem_word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_cnt,
  output logic        word_ready
);

  logic [31:0] word_q;
  logic [1:0]  byte_cnt_q;
  logic        word_ready_q;

  // NOTE: non-blocking assignments make every flop here update from pre-edge values,
  // so the byte slot selected by byte_cnt_q is the one in effect before the count moves.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      word_q       <= 32'h0;
      byte_cnt_q   <= 2'd0;
      word_ready_q <= 1'b0;
    end else if (byte_en) begin
      word_q[{byte_cnt_q, 3'b000} +: 8] <= byte_data;
      byte_cnt_q                        <= byte_cnt_q + 2'd1;
      word_ready_q                      <= (byte_cnt_q == 2'd3);
    end
  end

  assign word       = word_q;
  assign byte_cnt   = byte_cnt_q;
  assign word_ready = word_ready_q;

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory port owner: arbitrates the single memory port between CPU fetch
// and a byte-serial program loader, stalling the CPU while a load is in progress.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter int MEM_DEPTH = IMEM_DEPTH,
  parameter bit BOOT_RUN  = 1'b1
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic               LoadStart,
  input  logic [7:0]         LoadWords,
  input  logic               ByteValid,
  input  logic [7:0]         ByteData,
  output logic               ByteReady,
  input  logic [31:0]        PC,
  output logic [31:0]        Instr,
  output logic               CPUStall,
  output logic [IMEM_AW-1:0] MemAddr,
  output logic               MemWE,
  output logic [31:0]        MemWD,
  input  logic [31:0]        MemRD,
  output logic               LoadBusy,
  output logic               LoadDone
);

  localparam ctrl_state_e RESET_STATE = BOOT_RUN ? ST_RUN : ST_IDLE;

  ctrl_state_e        state_q, state_d;
  logic [IMEM_AW-1:0] ptr_q;
  logic [7:0]         count_q;
  logic               load_done_q;

  logic [31:0] pk_word;
  logic [1:0]  pk_cnt;
  logic        pk_ready;

  logic       start_ok;
  logic [7:0] start_count;
  logic       byte_accept;
  logic       last_byte;
  logic       last_word;
  logic       pk_clear;

  assign start_ok    = LoadStart && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign start_count = clamp_words(LoadWords, MEM_DEPTH);
  assign byte_accept = ByteValid && ByteReady;
  assign last_byte   = byte_accept && (pk_cnt == 2'd3);
  assign last_word   = ({1'b0, ptr_q} == (count_q - 8'd1));
  assign pk_clear    = start_ok || (state_q == ST_WRITE);

  imem_word_packer u_packer (
    .clk        (CLK),
    .rst        (Reset),
    .clear      (pk_clear),
    .byte_en    (byte_accept),
    .byte_data  (ByteData),
    .word       (pk_word),
    .byte_cnt   (pk_cnt),
    .word_ready (pk_ready)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_RUN: begin
        // A zero-word request never enters LOAD; it just reports completion.
        if (start_ok) state_d = (start_count == 8'd0) ? ST_RUN : ST_LOAD;
      end
      ST_LOAD:  if (last_byte) state_d = ST_WRITE;
      ST_WRITE: state_d = last_word ? ST_RUN : ST_LOAD;
      default:  state_d = RESET_STATE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= RESET_STATE;
      ptr_q       <= '0;
      count_q     <= 8'd0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_done_q <= (start_ok && (start_count == 8'd0)) || (last_byte && last_word);
      if (start_ok) begin
        ptr_q   <= '0;
        count_q <= start_count;
      end else if ((state_q == ST_WRITE) && !last_word) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no branch can
  // leave one unassigned and infer a latch.
  always_comb begin
    ByteReady = 1'b0;
    CPUStall  = 1'b1;
    Instr     = INSTR_NOP;
    MemAddr   = '0;
    LoadBusy  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        CPUStall = 1'b0;
        MemAddr  = PC[IMEM_AW+1:2];
        // Out-of-range or misaligned fetches see a NOP rather than aliased memory.
        if ((PC <= IMEM_MAX_BADDR) && (PC[1:0] == 2'b00)) Instr = MemRD;
      end
      ST_LOAD: begin
        ByteReady = 1'b1;
        MemAddr   = ptr_q;
        LoadBusy  = 1'b1;
      end
      ST_WRITE: begin
        MemAddr  = ptr_q;
        LoadBusy = 1'b1;
      end
      default: ;
    endcase
  end

  // The packer's ready flag is set by the fourth byte and cleared on leaving WRITE,
  // so it is high for exactly the WRITE cycle.
  assign MemWE    = pk_ready;
  assign MemWD    = pk_word;
  assign LoadDone = load_done_q;

endmodule
